imm_gen_pipe: RTL and testbench

//   Elastic, pipelined immediate generator for the RV32I datapath (next gen of the

---
 rtl/imm_gen_pipe_if.sv | 24 ++
 rtl/imm_gen_pipe.sv | 106 ++++++++++
 tb/tb_imm_gen_pipe.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus between decode, the immediate generator and execute.
// The master side drives instructions in and accepts immediates out.
interface imm_gen_pipe_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [2:0]      imm_src;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm_ext;
   logic            imm_err;

   modport master (
      output in_valid, instr, imm_src, out_ready,
      input  in_ready, out_valid, imm_ext, imm_err
   );

   modport slave (
      input  in_valid, instr, imm_src, out_ready,
      output in_ready, out_valid, imm_ext, imm_err
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// Elastic RV32I immediate generator: decodes I/S/B/J/U/Z formats and carries
// the result through STAGES skid-free pipeline registers with valid/ready flow.
module imm_gen_pipe #(
   parameter int XLEN   = 32,
   parameter int STAGES = 1,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   imm_gen_pipe_if.slave    bus,
   output logic [CNT_W-1:0] err_count
);
   typedef enum logic [2:0] {
      SRC_I = 3'b000,
      SRC_S = 3'b001,
      SRC_B = 3'b010,
      SRC_J = 3'b011,
      SRC_U = 3'b100,
      SRC_Z = 3'b101
   } src_e;

   logic [31:0]     raw;
   logic            err_d;
   logic [XLEN-1:0] imm_d;
   logic            acc;
   logic [31:0]     ins;

   assign ins = bus.instr;

   // Every format is first built as a 32-bit value whose bit 31 is the desired
   // fill bit (zero for Z), so one signed cast handles widening to XLEN.
   always_comb begin
      raw   = '0;
      err_d = 1'b0;
      case (src_e'(bus.imm_src))
         SRC_I:   raw = {{20{ins[31]}}, ins[31:20]};
         SRC_S:   raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         SRC_B:   raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         SRC_J:   raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         SRC_U:   raw = {ins[31:12], 12'b0};
         SRC_Z:   raw = {27'b0, ins[19:15]};
         default: err_d = 1'b1;
      endcase
   end

   assign imm_d = XLEN'($signed(raw));

   logic [STAGES:1]             vld_pipe;
   logic [STAGES:1]             err_pipe;
   logic [STAGES:1][XLEN-1:0]   imm_pipe;
   logic [STAGES:1]             vld_nxt;
   logic [STAGES:1]             err_nxt;
   logic [STAGES:1][XLEN-1:0]   imm_nxt;
   logic [STAGES+1:1]           rdy;

   assign rdy[STAGES+1] = bus.out_ready;
   assign vld_nxt[1]    = bus.in_valid;
   assign err_nxt[1]    = err_d;
   assign imm_nxt[1]    = imm_d;

   genvar k;
   for (k = 1; k <= STAGES; k++) begin : g_rdy
      assign rdy[k] = !vld_pipe[k] | rdy[k+1];
   end
   for (k = 2; k <= STAGES; k++) begin : g_fwd
      assign vld_nxt[k] = vld_pipe[k-1];
      assign err_nxt[k] = err_pipe[k-1];
      assign imm_nxt[k] = imm_pipe[k-1];
   end

   assign bus.in_ready = rdy[1] & !rst;
   assign acc          = bus.in_valid & bus.in_ready & !flush;

   // A stage loads whenever its downstream can drain; data only moves with a valid item.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         err_pipe <= '0;
         imm_pipe <= '0;
      end else if (flush) begin
         vld_pipe <= '0;
      end else begin
         for (int s = 1; s <= STAGES; s++) begin
            if (rdy[s]) begin
               vld_pipe[s] <= vld_nxt[s];
               if (vld_nxt[s]) begin
                  err_pipe[s] <= err_nxt[s];
                  imm_pipe[s] <= imm_nxt[s];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (acc && err_d && err_count != {CNT_W{1'b1}})
         err_count <= err_count + 1'b1;
   end

   assign bus.out_valid = vld_pipe[STAGES];
   assign bus.imm_ext   = imm_pipe[STAGES];
   assign bus.imm_err   = err_pipe[STAGES];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: dut_a is XLEN=32/STAGES=1/CNT_W=8, dut_b is XLEN=64/STAGES=2/CNT_W=2.
// A vector table exercises every format, then hand sequences cover stall, saturation and flush.
module tb_imm_gen_pipe;
   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32)) ia ();
   imm_gen_pipe_if #(.XLEN(64)) ib ();

   imm_gen_pipe #(.XLEN(32), .STAGES(1), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .bus(ia), .err_count(cnt_a));
   imm_gen_pipe #(.XLEN(64), .STAGES(2), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .bus(ib), .err_count(cnt_b));

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [63:0] exp;
      logic        err;
   } vec_t;
   vec_t tv[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic va, input logic vb, input logic [31:0] ins, input logic [2:0] src);
      ia.in_valid = va;  ia.instr = ins;  ia.imm_src = src;
      ib.in_valid = vb;  ib.instr = ins;  ib.imm_src = src;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tv[0] = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
      tv[1] = '{32'h7FF00093, 3'b000, 64'h00000000_000007FF, 1'b0};
      tv[2] = '{32'hFE112E23, 3'b001, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
      tv[3] = '{32'hFE000EE3, 3'b010, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
      tv[4] = '{32'h0080006F, 3'b011, 64'h00000000_00000008, 1'b0};
      tv[5] = '{32'h123450B7, 3'b100, 64'h00000000_12345000, 1'b0};
      tv[6] = '{32'h800000B7, 3'b100, 64'hFFFFFFFF_80000000, 1'b0};
      tv[7] = '{32'h800F8073, 3'b101, 64'h00000000_0000001F, 1'b0};
      tv[8] = '{32'hFFFFFFFF, 3'b110, 64'h0, 1'b1};

      rst = 1'b1;
      flush = 1'b0;
      ia.out_ready = 1'b1;
      ib.out_ready = 1'b1;
      drive(1'b1, 1'b1, 32'hFFF00093, 3'b000);
      tick();
      tick();
      chk("rst in_ready_a", 64'(ia.in_ready), 64'd0);
      chk("rst in_ready_b", 64'(ib.in_ready), 64'd0);
      chk("rst out_valid_a", 64'(ia.out_valid), 64'd0);
      chk("rst out_valid_b", 64'(ib.out_valid), 64'd0);
      chk("rst imm_a", 64'(ia.imm_ext), 64'd0);
      chk("rst cnt_a", 64'(cnt_a), 64'd0);
      drive(1'b0, 1'b0, 32'h0, 3'b000);
      rst = 1'b0;
      #1;
      chk("post-rst in_ready_a", 64'(ia.in_ready), 64'd1);

      // Table: each vector goes into both DUTs; a shows it after 1 edge, b after 2.
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b1, tv[i].instr, tv[i].src);
         tick();
         drive(1'b0, 1'b0, 32'h0, 3'b000);
         chk($sformatf("vec%0d a valid", i), 64'(ia.out_valid), 64'd1);
         chk($sformatf("vec%0d a imm", i), 64'(ia.imm_ext), {32'h0, tv[i].exp[31:0]});
         chk($sformatf("vec%0d a err", i), 64'(ia.imm_err), 64'(tv[i].err));
         chk($sformatf("vec%0d b early", i), 64'(ib.out_valid), 64'd0);
         tick();
         chk($sformatf("vec%0d b valid", i), 64'(ib.out_valid), 64'd1);
         chk($sformatf("vec%0d b imm", i), ib.imm_ext, tv[i].exp);
         chk($sformatf("vec%0d b err", i), 64'(ib.imm_err), 64'(tv[i].err));
         chk($sformatf("vec%0d a drained", i), 64'(ia.out_valid), 64'd0);
      end
      chk("table cnt_a", 64'(cnt_a), 64'd1);
      chk("table cnt_b", 64'(cnt_b), 64'd1);

      rst = 1'b1;
      tick();
      chk("rst2 out_valid_b", 64'(ib.out_valid), 64'd0);
      chk("rst2 cnt_a", 64'(cnt_a), 64'd0);
      rst = 1'b0;

      // Three back-to-back illegal items on a: one per cycle, no bubbles.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'hFFFFFFFF - i, 3'b111);
         tick();
         chk($sformatf("ill%0d valid", i), 64'(ia.out_valid), 64'd1);
         chk($sformatf("ill%0d imm", i), 64'(ia.imm_ext), 64'd0);
         chk($sformatf("ill%0d err", i), 64'(ia.imm_err), 64'd1);
         chk($sformatf("ill%0d in_ready", i), 64'(ia.in_ready), 64'd1);
      end
      drive(1'b0, 1'b0, 32'h0, 3'b000);
      chk("ill cnt_a", 64'(cnt_a), 64'd3);

      // Five illegal items into the 2-bit counter of b: saturates at 3.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 32'h0, 3'b110);
         tick();
      end
      drive(1'b0, 1'b0, 32'h0, 3'b000);
      tick();
      tick();
      chk("sat cnt_b", 64'(cnt_b), 64'd3);

      // Stall on b: two items fill both stages and are held in order.
      ib.out_ready = 1'b0;
      drive(1'b0, 1'b1, 32'hFFF00093, 3'b000);
      tick();
      drive(1'b0, 1'b1, 32'h123450B7, 3'b100);
      tick();
      drive(1'b0, 1'b0, 32'h0, 3'b000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall%0d in_ready", i), 64'(ib.in_ready), 64'd0);
         chk($sformatf("stall%0d valid", i), 64'(ib.out_valid), 64'd1);
         chk($sformatf("stall%0d imm", i), ib.imm_ext, 64'hFFFFFFFF_FFFFFFFF);
      end
      ib.out_ready = 1'b1;
      #1;
      chk("unstall in_ready", 64'(ib.in_ready), 64'd1);
      tick();
      chk("order item2 valid", 64'(ib.out_valid), 64'd1);
      chk("order item2 imm", ib.imm_ext, 64'h00000000_12345000);
      tick();
      chk("order drained", 64'(ib.out_valid), 64'd0);

      // Flush: b full and stalled, a empty with an illegal item offered.
      ib.out_ready = 1'b0;
      drive(1'b0, 1'b1, 32'h0080006F, 3'b011);
      tick();
      tick();
      drive(1'b1, 1'b1, 32'h0, 3'b111);
      flush = 1'b1;
      #1;
      chk("flush in_ready_a", 64'(ia.in_ready), 64'd1);
      chk("flush full b", 64'(ib.out_valid), 64'd1);
      tick();
      flush = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 3'b000);
      chk("flush out_valid_b", 64'(ib.out_valid), 64'd0);
      chk("flush out_valid_a", 64'(ia.out_valid), 64'd0);
      chk("flush cnt_a", 64'(cnt_a), 64'd3);
      chk("flush cnt_b", 64'(cnt_b), 64'd3);
      ib.out_ready = 1'b1;

      drive(1'b1, 1'b0, 32'h800F8073, 3'b101);
      tick();
      drive(1'b0, 1'b0, 32'h0, 3'b000);
      chk("post-flush a valid", 64'(ia.out_valid), 64'd1);
      chk("post-flush a imm", 64'(ia.imm_ext), 64'h1F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
